// File: rtl/bcd_time_counter.sv
// Minutes:seconds BCD counter with per-field limits, up/down counting,
// an adjust mode, an edge-detected pause toggle and a rollover pulse.
module bcd_time_counter #(
  parameter int MIN_MAX = 99,
  parameter int SEC_MAX = 59
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_tick,
  input  logic       in_adj_tick,
  input  logic       in_pause,
  input  logic       in_adjust,
  input  logic       in_select,
  input  logic       in_down,
  output logic [3:0] out_minute1,
  output logic [3:0] out_minute0,
  output logic [3:0] out_second1,
  output logic [3:0] out_second0,
  output logic       out_paused,
  output logic       out_wrap
);

  // Field limits as whole values and as their BCD digit pairs.
  localparam logic [6:0] MMAX = 7'(MIN_MAX);
  localparam logic [6:0] SMAX = 7'(SEC_MAX);
  localparam logic [3:0] MMAX_T = 4'(MIN_MAX / 10);
  localparam logic [3:0] MMAX_O = 4'(MIN_MAX % 10);
  localparam logic [3:0] SMAX_T = 4'(SEC_MAX / 10);
  localparam logic [3:0] SMAX_O = 4'(SEC_MAX % 10);

  logic [3:0] min1_q, min1_d;
  logic [3:0] min0_q, min0_d;
  logic [3:0] sec1_q, sec1_d;
  logic [3:0] sec0_q, sec0_d;
  logic       paused_q, paused_d;
  logic       pprev_q, pprev_d;
  logic       wrap_q, wrap_d;

  // Whole field value of a tens/ones digit pair.
  function automatic logic [6:0] fval(
    input logic [3:0] t,
    input logic [3:0] o
  );
    return 7'(t) * 7'd10 + 7'(o);
  endfunction

  // Next digit pair one step up, wrapping to zero past the limit.
  function automatic logic [7:0] inc_f(
    input logic [3:0] t,
    input logic [3:0] o,
    input logic       at_max
  );
    logic [7:0] r;
    if (at_max)
      r = 8'h00;
    else if (o == 4'd9)
      r = {t + 4'd1, 4'd0};
    else
      r = {t, o + 4'd1};
    return r;
  endfunction

  // Next digit pair one step down, wrapping from zero to the limit.
  function automatic logic [7:0] dec_f(
    input logic [3:0] t,
    input logic [3:0] o,
    input logic       at_zero,
    input logic [3:0] mt,
    input logic [3:0] mo
  );
    logic [7:0] r;
    if (at_zero)
      r = {mt, mo};
    else if (o == 4'd0)
      r = {t - 4'd1, 4'd9};
    else
      r = {t, o - 4'd1};
    return r;
  endfunction

  logic       sec_max, sec_zero;
  logic       min_max, min_zero;
  logic [7:0] sec_up, sec_dn;
  logic [7:0] min_up, min_dn;
  logic       run, adj;

  // Limit detection and candidate next values for both fields.
  always_comb begin
    sec_max  = fval(sec1_q, sec0_q) == SMAX;
    sec_zero = fval(sec1_q, sec0_q) == 7'd0;
    min_max  = fval(min1_q, min0_q) == MMAX;
    min_zero = fval(min1_q, min0_q) == 7'd0;
    sec_up   = inc_f(sec1_q, sec0_q, sec_max);
    min_up   = inc_f(min1_q, min0_q, min_max);
    sec_dn   = dec_f(sec1_q, sec0_q, sec_zero,
                     SMAX_T, SMAX_O);
    min_dn   = dec_f(min1_q, min0_q, min_zero,
                     MMAX_T, MMAX_O);
    run      = !in_adjust && in_tick && !paused_q;
    adj      = in_adjust && in_adj_tick;
  end

  // Next-state selection: normal counting with carry, or field adjust.
  always_comb begin
    min1_d = min1_q;
    min0_d = min0_q;
    sec1_d = sec1_q;
    sec0_d = sec0_q;
    wrap_d = 1'b0;
    if (run) begin
      if (!in_down) begin
        {sec1_d, sec0_d} = sec_up;
        if (sec_max) begin
          {min1_d, min0_d} = min_up;
          wrap_d = min_max;
        end
      end else begin
        {sec1_d, sec0_d} = sec_dn;
        if (sec_zero) begin
          {min1_d, min0_d} = min_dn;
          wrap_d = min_zero;
        end
      end
    end else if (adj) begin
      if (in_select)
        {sec1_d, sec0_d} = in_down ? sec_dn : sec_up;
      else
        {min1_d, min0_d} = in_down ? min_dn : min_up;
    end
  end

  // Pause toggles on each rising edge of the pause level.
  always_comb begin
    pprev_d  = in_pause;
    paused_d = paused_q ^ (in_pause & ~pprev_q);
  end

  // State registers; pause history resets high to ignore a held button.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      min1_q   <= 4'd0;
      min0_q   <= 4'd0;
      sec1_q   <= 4'd0;
      sec0_q   <= 4'd0;
      paused_q <= 1'b0;
      pprev_q  <= 1'b1;
      wrap_q   <= 1'b0;
    end else begin
      min1_q   <= min1_d;
      min0_q   <= min0_d;
      sec1_q   <= sec1_d;
      sec0_q   <= sec0_d;
      paused_q <= paused_d;
      pprev_q  <= pprev_d;
      wrap_q   <= wrap_d;
    end
  end

  assign out_minute1 = min1_q;
  assign out_minute0 = min0_q;
  assign out_second1 = sec1_q;
  assign out_second0 = sec0_q;
  assign out_paused  = paused_q;
  assign out_wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: default (99:59) and small (05:09)
// instances share stimulus and are checked against a total-count model.
module tb_bcd_time_counter;

  logic clk = 1'b0;
  logic in_reset = 1'b0;
  logic in_tick = 1'b0;
  logic in_adj_tick = 1'b0;
  logic in_pause = 1'b0;
  logic in_adjust = 1'b0;
  logic in_select = 1'b0;
  logic in_down = 1'b0;

  logic [1:0][3:0] dm1, dm0, ds1, ds0;
  logic [1:0] dp, dw;

  always #5 clk = ~clk;

  bcd_time_counter #(.MIN_MAX(99), .SEC_MAX(59)) u_a (
    .in_clock(clk), .in_reset(in_reset),
    .in_tick(in_tick), .in_adj_tick(in_adj_tick),
    .in_pause(in_pause), .in_adjust(in_adjust),
    .in_select(in_select), .in_down(in_down),
    .out_minute1(dm1[0]), .out_minute0(dm0[0]),
    .out_second1(ds1[0]), .out_second0(ds0[0]),
    .out_paused(dp[0]), .out_wrap(dw[0])
  );

  bcd_time_counter #(.MIN_MAX(5), .SEC_MAX(9)) u_b (
    .in_clock(clk), .in_reset(in_reset),
    .in_tick(in_tick), .in_adj_tick(in_adj_tick),
    .in_pause(in_pause), .in_adjust(in_adjust),
    .in_select(in_select), .in_down(in_down),
    .out_minute1(dm1[1]), .out_minute0(dm0[1]),
    .out_second1(ds1[1]), .out_second0(ds0[1]),
    .out_paused(dp[1]), .out_wrap(dw[1])
  );

  int vecs = 0;
  int errs = 0;

  int MX[2] = '{99, 5};
  int SX[2] = '{59, 9};
  int mm[2], ms[2];
  bit mp[2], mprev[2], mw[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mm[k] = 0; ms[k] = 0;
      mp[k] = 0; mprev[k] = 1; mw[k] = 0;
    end
  endtask

  // Time is one total count modulo (MIN_MAX+1)*(SEC_MAX+1).
  task automatic model_step();
    int n, t, sm;
    for (int k = 0; k < 2; k++) begin
      mw[k] = 0;
      sm = SX[k] + 1;
      if (!in_adjust && in_tick && !mp[k]) begin
        n = (MX[k] + 1) * sm;
        t = mm[k] * sm + ms[k];
        if (!in_down) begin
          t = (t + 1) % n;
          mw[k] = (t == 0);
        end else begin
          t = (t + n - 1) % n;
          mw[k] = (t == n - 1);
        end
        mm[k] = t / sm;
        ms[k] = t % sm;
      end else if (in_adjust && in_adj_tick) begin
        if (in_select)
          ms[k] = in_down ? (ms[k] + SX[k]) % sm
                          : (ms[k] + 1) % sm;
        else
          mm[k] = in_down ? (mm[k] + MX[k]) % (MX[k] + 1)
                          : (mm[k] + 1) % (MX[k] + 1);
      end
      if (in_pause && !mprev[k]) mp[k] = !mp[k];
      mprev[k] = in_pause;
    end
  endtask

  task automatic chk(string name, int k,
                     int em, int es, bit ep, bit ew);
    logic [15:0] exp_d, act_d;
    exp_d = {4'(em / 10), 4'(em % 10), 4'(es / 10), 4'(es % 10)};
    act_d = {dm1[k], dm0[k], ds1[k], ds0[k]};
    vecs++;
    if (act_d !== exp_d || dp[k] !== ep || dw[k] !== ew) begin
      errs++;
      $display("FAIL %s inst%0d: got %h p=%b w=%b, want %h p=%b w=%b",
               name, k, act_d, dp[k], dw[k], exp_d, ep, ew);
    end
  endtask

  task automatic chk_model(string name);
    for (int k = 0; k < 2; k++)
      chk(name, k, mm[k], ms[k], mp[k], mw[k]);
  endtask

  task automatic cyc(string name);
    @(posedge clk);
    model_step();
    #1;
    chk_model(name);
  endtask

  // Reset is raised away from the clock edge so clearing is seen async.
  task automatic do_reset();
    in_reset = 1'b1;
    #1;
    model_reset();
    chk_model("async_reset");
    @(posedge clk);
    #1;
    in_reset = 1'b0;
  endtask

  task automatic idle();
    in_tick = 0; in_adj_tick = 0;
  endtask

  typedef struct {
    bit adj, sel, dn, tk, at;
    int em, es;
    bit ew;
  } vec_t;
  vec_t tbl[13];

  bit saw_wrap;

  initial begin
    tbl[0]  = '{1, 1, 1, 0, 1, 0, 59, 0};
    tbl[1]  = '{1, 0, 1, 0, 1, 99, 59, 0};
    tbl[2]  = '{0, 0, 0, 1, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 1, 1, 0, 99, 59, 1};
    tbl[5]  = '{0, 0, 1, 1, 0, 99, 58, 0};
    tbl[6]  = '{1, 0, 0, 1, 0, 99, 58, 0};
    tbl[7]  = '{0, 0, 0, 0, 1, 99, 58, 0};
    tbl[8]  = '{1, 1, 0, 0, 1, 99, 59, 0};
    tbl[9]  = '{1, 1, 0, 0, 1, 99, 0, 0};
    tbl[10] = '{1, 0, 0, 0, 1, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 1, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 1, 0, 1, 1, 0};

    #2;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      in_adjust = tbl[i].adj; in_select = tbl[i].sel;
      in_down = tbl[i].dn; in_tick = tbl[i].tk;
      in_adj_tick = tbl[i].at;
      cyc("table_model");
      chk($sformatf("table_%0d", i), 0,
          tbl[i].em, tbl[i].es, 1'b0, tbl[i].ew);
    end
    idle(); in_adjust = 0; in_down = 0;

    // 60 up ticks from reset reach 01:00 without rollover.
    do_reset();
    saw_wrap = 0;
    in_tick = 1;
    for (int i = 0; i < 60; i++) begin
      cyc("up60");
      if (dw[0]) saw_wrap = 1;
    end
    idle();
    chk("up60_end", 0, 1, 0, 1'b0, saw_wrap);

    // Small instance counting down from 00:00.
    do_reset();
    in_down = 1; in_tick = 1;
    cyc("down_small");
    chk("down_wrap", 1, 5, 9, 1'b0, 1'b1);
    cyc("down_small");
    chk("down_next", 1, 5, 8, 1'b0, 1'b0);
    idle(); in_down = 0;

    // Pause edge coincident with a tick: tick counts, then frozen.
    do_reset();
    in_pause = 0;
    in_tick = 1;
    cyc("pause_pre");
    cyc("pause_pre");
    in_pause = 1;
    cyc("pause_edge");
    chk("pause_edge", 0, 0, 3, 1'b1, 1'b0);
    in_pause = 0;
    for (int i = 0; i < 5; i++) cyc("paused_hold");
    chk("paused_frozen", 0, 0, 3, 1'b1, 1'b0);
    in_pause = 1;
    cyc("resume_edge");
    chk("resume_edge", 0, 0, 3, 1'b0, 1'b0);
    in_pause = 0;
    cyc("resumed");
    chk("resumed", 0, 0, 4, 1'b0, 1'b0);
    idle();

    // Pause held high through reset release must not toggle.
    in_pause = 1;
    do_reset();
    for (int i = 0; i < 3; i++) cyc("pause_held");
    chk("pause_held", 0, 0, 0, 1'b0, 1'b0);
    in_pause = 0;

    // Preload 12:34 then reset mid-count.
    in_adjust = 1; in_adj_tick = 1;
    in_select = 0;
    for (int i = 0; i < 12; i++) cyc("load_min");
    in_select = 1;
    for (int i = 0; i < 34; i++) cyc("load_sec");
    idle(); in_adjust = 0;
    in_tick = 1;
    cyc("mid_count");
    chk("at_12_35", 0, 12, 35, 1'b0, 1'b0);
    idle();
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_tick = ($urandom_range(0, 2) == 0);
      in_adj_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) in_adjust = ~in_adjust;
      if ($urandom_range(0, 7) == 0) in_select = ~in_select;
      if ($urandom_range(0, 31) == 0) in_down = ~in_down;
      if ($urandom_range(0, 9) == 0) in_pause = ~in_pause;
      cyc("random");
      if (i == 1500) begin
        idle();
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
